// File: rtl/mem_wb_stage_if.sv
// Data-cache request/response bus between the memory stage (master) and the cache (slave).
// The request is held stable by the master until dhit returns.
interface mem_wb_stage_if #(
    parameter int WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB register: writeback is 1 cycle after the dhit cycle (0 added on a hit).
// Backpressure: stall freezes upstream while a cache access is outstanding; halt is sticky until reset.
module mem_wb_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [1:0]         memtoreg_in,
    input  logic               regwrite_in,
    input  logic               dmemREN_in,
    input  logic               dmemWEN_in,
    input  logic               halt_in,
    input  logic [WORD_W-1:0]  aluResult_in,
    input  logic [WORD_W-1:0]  rdat2_in,
    input  logic [WORD_W-1:0]  npc_in,
    input  logic [WORD_W-1:0]  upper16_in,
    input  logic [REG_W-1:0]   wsel_in,
    mem_wb_stage_if.master     dbus,
    output logic               regwrite_wb,
    output logic [REG_W-1:0]   wsel_wb,
    output logic [WORD_W-1:0]  wdat_wb,
    output logic               halt_wb,
    output logic               stall,
    output logic [31:0]        miss_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               regwrite_wb_q, regwrite_wb_d;
    logic [REG_W-1:0]   wsel_wb_q, wsel_wb_d;
    logic [WORD_W-1:0]  wdat_wb_q, wdat_wb_d;
    logic               halt_wb_q, halt_wb_d;
    logic [31:0]        miss_cycles_q, miss_cycles_d;

    logic               req_vld;
    logic               upd;
    logic [WORD_W-1:0]  wdat_sel;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (upd && halt_in) begin
                    state_d = HALTED;
                end else if (stall) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (upd) begin
                    state_d = halt_in ? HALTED : IDLE;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; nRST gates the request so an access aborts the instant reset asserts
    always_comb begin
        req_vld        = 1'b0;
        dbus.dmemREN   = 1'b0;
        dbus.dmemWEN   = 1'b0;
        dbus.dmemaddr  = aluResult_in;
        dbus.dmemstore = rdat2_in;
        stall          = 1'b0;
        upd            = 1'b0;
        if (state_q != HALTED) begin
            req_vld = nRST && (dmemREN_in || dmemWEN_in) && !halt_wb_q;
            if (req_vld) begin
                dbus.dmemREN = dmemREN_in;
                dbus.dmemWEN = dmemWEN_in;
                stall        = !dbus.dhit;
            end
            upd = !stall;
        end
    end

    always_comb begin
        unique case (memtoreg_in)
            2'b00:   wdat_sel = aluResult_in;
            2'b01:   wdat_sel = dbus.dmemload;
            2'b10:   wdat_sel = npc_in;
            default: wdat_sel = upper16_in;
        endcase
    end

    // MEM/WB bundle: load on update, bubble while stalled, hold once halted
    always_comb begin
        regwrite_wb_d = regwrite_wb_q;
        wsel_wb_d     = wsel_wb_q;
        wdat_wb_d     = wdat_wb_q;
        halt_wb_d     = halt_wb_q;
        miss_cycles_d = miss_cycles_q;
        if (upd) begin
            regwrite_wb_d = regwrite_in;
            wsel_wb_d     = wsel_in;
            wdat_wb_d     = wdat_sel;
            halt_wb_d     = halt_in;
        end else if (stall) begin
            regwrite_wb_d = 1'b0;
        end
        if (stall && (miss_cycles_q != 32'hFFFF_FFFF)) begin
            miss_cycles_d = miss_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regwrite_wb_q <= 1'b0;
            wsel_wb_q     <= '0;
            wdat_wb_q     <= '0;
            halt_wb_q     <= 1'b0;
            miss_cycles_q <= '0;
        end else begin
            regwrite_wb_q <= regwrite_wb_d;
            wsel_wb_q     <= wsel_wb_d;
            wdat_wb_q     <= wdat_wb_d;
            halt_wb_q     <= halt_wb_d;
            miss_cycles_q <= miss_cycles_d;
        end
    end

    assign regwrite_wb = regwrite_wb_q;
    assign wsel_wb     = wsel_wb_q;
    assign wdat_wb     = wdat_wb_q;
    assign halt_wb     = halt_wb_q;
    assign miss_cycles = miss_cycles_q;

endmodule
